// File: rtl/mem_pkg.sv
// mem_pkg: response type, latency ceiling and byte-lane merge helper shared by obi_sram.
package mem_pkg;
  localparam int RESP_DATA_W = 32;
  localparam int MAX_LATENCY = 8;
  localparam int MAX_DATA_W = 1024;
  typedef struct packed {
    logic valid;
    logic err;
    logic [RESP_DATA_W-1:0] rdata;
  } mem_resp_t;
  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old,
    input logic [MAX_DATA_W-1:0] wdata,
    input logic [MAX_DATA_W/8-1:0] be
  );
    logic [MAX_DATA_W-1:0] r;
    for (int i = 0; i < MAX_DATA_W / 8; i++) r[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/mem_resp_pipe.sv
// mem_resp_pipe: fixed-latency response shift register; the last stage is the registered response.
module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter type resp_t = mem_resp_t
) (
  input  logic  clk,
  input  logic  rst,
  input  resp_t d,
  output resp_t q,
  output logic  retire
);
  resp_t [LATENCY-1:0] stage;
  always_ff @(posedge clk or posedge rst)
    if (rst) stage <= '0;
    else begin
      stage[0] <= d;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  assign q = stage[LATENCY-1];
  assign retire = q.valid;
endmodule

// File: rtl/obi_sram.sv
// obi_sram: single-port word memory with req/gnt/rvalid handshake, fixed response latency,
// outstanding-request limit, byte-lane writes, range error and optional grant-stall injection.
module obi_sram
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8192,
  parameter int LATENCY = 1,
  parameter int MAX_OUT = 2,
  parameter int STALL_PERIOD = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_req_in,
  input  logic [31:0]         mem_add_in,
  input  logic                mem_we_in,
  input  logic [DATA_W/8-1:0] mem_be_in,
  input  logic [DATA_W-1:0]   mem_wdata_in,
  output logic                mem_gnt_o,
  output logic                mem_rvalid_o,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = STALL_PERIOD > 1 ? $clog2(STALL_PERIOD + 1) : 1;
  typedef struct packed {
    logic valid;
    logic err;
    logic [DATA_W-1:0] rdata;
  } resp_t;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic in_range, retire, stall, addr_unused;
  logic [CW-1:0] out_cnt;
  logic [SW-1:0] stall_cnt;
  logic [SW:0] stall_nxt;
  resp_t d, q;
  assign idx = mem_add_in[AW+1:2];
  assign in_range = mem_add_in[31:AW+2] == '0;
  assign addr_unused = ^mem_add_in[1:0];
  assign stall_nxt = {1'b0, stall_cnt} + (SW+1)'(1);
  // STALL_PERIOD of 0 never matches a nonzero stall_nxt, so stalls stay disabled
  assign stall = mem_req_in && stall_nxt == (SW+1)'(STALL_PERIOD);
  assign mem_gnt_o = mem_req_in && !reset && (out_cnt < CW'(MAX_OUT) || retire) && !stall;
  always_comb begin
    d = '0;
    d.valid = mem_gnt_o;
    d.err = mem_gnt_o && !in_range;
    d.rdata = mem_gnt_o && in_range && !mem_we_in ? mem[idx] : '0;
  end
  always_ff @(posedge clk)
    if (mem_gnt_o && mem_we_in && in_range)
      mem[idx] <= DATA_W'(be_merge(MAX_DATA_W'(mem[idx]), MAX_DATA_W'(mem_wdata_in), (MAX_DATA_W/8)'(mem_be_in)));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(mem_gnt_o) - CW'(retire);
      if (mem_req_in) stall_cnt <= stall ? '0 : stall_nxt[SW-1:0];
    end
  mem_resp_pipe #(.LATENCY(LATENCY), .resp_t(resp_t)) u_pipe (
    .clk(clk),
    .rst(reset),
    .d(d),
    .q(q),
    .retire(retire)
  );
  assign mem_rvalid_o = q.valid;
  assign mem_rdata_o = q.rdata;
  assign mem_err_o = q.err;
endmodule

// File: tb/tb_obi_sram.sv
// tb_obi_sram: directed checks of five obi_sram configurations sharing one clock and request bus.
module tb_obi_sram;
  logic clk = 0, reset = 1, we = 0;
  logic [4:0] req = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] be = '0;
  logic [4:0] gnt, rvalid, err;
  logic [31:0] rdata [5];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  obi_sram #(.LATENCY(3)) u_a (.clk(clk), .reset(reset), .mem_req_in(req[0]), .mem_add_in(addr), .mem_we_in(we), .mem_be_in(be), .mem_wdata_in(wdata), .mem_gnt_o(gnt[0]), .mem_rvalid_o(rvalid[0]), .mem_rdata_o(rdata[0]), .mem_err_o(err[0]));
  obi_sram #(.LATENCY(1)) u_b (.clk(clk), .reset(reset), .mem_req_in(req[1]), .mem_add_in(addr), .mem_we_in(we), .mem_be_in(be), .mem_wdata_in(wdata), .mem_gnt_o(gnt[1]), .mem_rvalid_o(rvalid[1]), .mem_rdata_o(rdata[1]), .mem_err_o(err[1]));
  obi_sram #(.LATENCY(2), .MAX_OUT(3)) u_c (.clk(clk), .reset(reset), .mem_req_in(req[2]), .mem_add_in(addr), .mem_we_in(we), .mem_be_in(be), .mem_wdata_in(wdata), .mem_gnt_o(gnt[2]), .mem_rvalid_o(rvalid[2]), .mem_rdata_o(rdata[2]), .mem_err_o(err[2]));
  obi_sram #(.LATENCY(4), .MAX_OUT(2)) u_d (.clk(clk), .reset(reset), .mem_req_in(req[3]), .mem_add_in(addr), .mem_we_in(we), .mem_be_in(be), .mem_wdata_in(wdata), .mem_gnt_o(gnt[3]), .mem_rvalid_o(rvalid[3]), .mem_rdata_o(rdata[3]), .mem_err_o(err[3]));
  obi_sram #(.LATENCY(1), .STALL_PERIOD(3)) u_e (.clk(clk), .reset(reset), .mem_req_in(req[4]), .mem_add_in(addr), .mem_we_in(we), .mem_be_in(be), .mem_wdata_in(wdata), .mem_gnt_o(gnt[4]), .mem_rvalid_o(rvalid[4]), .mem_rdata_o(rdata[4]), .mem_err_o(err[4]));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [4:0] r, input logic w, input logic [31:0] a, input logic [31:0] dt, input logic [3:0] b);
    req = r;
    we = w;
    addr = a;
    wdata = dt;
    be = b;
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    int n, rcnt;
    logic g;
    int gd [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    int rd [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1};
    tick;
    tick;
    chk("rst_rvalid_a", 32'(rvalid[0]), 0);
    chk("rst_rdata_a", rdata[0], 0);
    chk("rst_err_b", 32'(err[1]), 0);
    chk("rst_rvalid_e", 32'(rvalid[4]), 0);
    drive(5'b00001, 0, 32'h10, 0, 0);
    chk("gnt_in_reset", 32'(gnt[0]), 0);
    reset = 0;
    drive(5'b00001, 1, 32'h10, 32'hCAFEF00D, 4'hF);
    chk("a_wr_gnt", 32'(gnt[0]), 1);
    tick;
    req = '0;
    tick;
    chk("a_wr_lat_early", 32'(rvalid[0]), 0);
    tick;
    chk("a_wr_rvalid", 32'(rvalid[0]), 1);
    chk("a_wr_rdata", rdata[0], 0);
    tick;
    chk("a_wr_done", 32'(rvalid[0]), 0);
    drive(5'b00001, 0, 32'h10, 0, 0);
    chk("a_rd_gnt", 32'(gnt[0]), 1);
    tick;
    reset = 1;
    drive(5'b00001, 0, 32'h10, 0, 0);
    chk("a_gnt_reset", 32'(gnt[0]), 0);
    chk("a_rvalid_reset", 32'(rvalid[0]), 0);
    tick;
    reset = 0;
    req = '0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("a_dropped", 32'(rvalid[0]), 0);
    end
    drive(5'b00001, 0, 32'h10, 0, 0);
    chk("a_rd2_gnt", 32'(gnt[0]), 1);
    tick;
    req = '0;
    tick;
    chk("a_rd2_early", 32'(rvalid[0]), 0);
    tick;
    chk("a_rd2_rvalid", 32'(rvalid[0]), 1);
    chk("a_rd2_rdata", rdata[0], 32'hCAFEF00D);
    drive(5'b00010, 1, 32'h4, 32'h11223344, 4'hF);
    tick;
    chk("b_wr0_rvalid", 32'(rvalid[1]), 1);
    chk("b_wr0_rdata", rdata[1], 0);
    drive(5'b00010, 1, 32'h4, 32'hDEADBEEF, 4'b0101);
    tick;
    chk("b_wr1_rdata", rdata[1], 0);
    drive(5'b00010, 0, 32'h4, 0, 0);
    tick;
    chk("b_merge_rvalid", 32'(rvalid[1]), 1);
    chk("b_merge_rdata", rdata[1], 32'h11AD33EF);
    drive(5'b00010, 1, 32'h4, 32'hFFFFFFFF, 4'h0);
    tick;
    drive(5'b00010, 0, 32'h4, 0, 0);
    tick;
    chk("b_be0_noop", rdata[1], 32'h11AD33EF);
    drive(5'b00010, 0, 32'h8000, 0, 0);
    tick;
    chk("b_oor_rvalid", 32'(rvalid[1]), 1);
    chk("b_oor_err", 32'(err[1]), 1);
    chk("b_oor_rdata", rdata[1], 0);
    drive(5'b00010, 1, 32'h0, 32'h01020304, 4'hF);
    tick;
    drive(5'b00010, 1, 32'h10000, 32'hFFFFFFFF, 4'hF);
    tick;
    chk("b_oor_wr_err", 32'(err[1]), 1);
    drive(5'b00010, 0, 32'h0, 0, 0);
    tick;
    chk("b_word0_kept", rdata[1], 32'h01020304);
    chk("b_word0_err", 32'(err[1]), 0);
    req = '0;
    tick;
    chk("b_idle_rvalid", 32'(rvalid[1]), 0);
    for (int i = 0; i < 6; i++) begin
      drive(5'b00100, 1, 32'(4 * i), 32'h10000000 + 32'(i), 4'hF);
      chk("c_wr_gnt", 32'(gnt[2]), 1);
      tick;
    end
    req = '0;
    tick;
    tick;
    for (int i = 0; i < 6; i++) begin
      drive(5'b00100, 0, 32'(4 * i), 0, 0);
      chk("c_rd_gnt", 32'(gnt[2]), 1);
      tick;
      if (i > 0) begin
        chk("c_rvalid", 32'(rvalid[2]), 1);
        chk("c_rdata", rdata[2], 32'h10000000 + 32'(i - 1));
      end else chk("c_first_early", 32'(rvalid[2]), 0);
    end
    req = '0;
    tick;
    chk("c_last_rdata", rdata[2], 32'h10000005);
    tick;
    chk("c_drained", 32'(rvalid[2]), 0);
    for (int k = 0; k < 10; k++) begin
      drive(5'b01000, 0, 32'h0, 0, 0);
      chk("d_gnt", 32'(gnt[3]), 32'(gd[k]));
      chk("d_retire", 32'(rvalid[3]), 32'(rd[k]));
      tick;
    end
    req = '0;
    for (int i = 0; i < 5; i++) tick;
    chk("d_drained", 32'(rvalid[3]), 0);
    n = 0;
    for (int k = 0; k < 9; k++) begin
      g = (k % 3) != 2;
      drive(5'b10000, 1, 32'(4 * n), 32'hE0 + 32'(n), 4'hF);
      chk("e_wr_gnt", 32'(gnt[4]), 32'(g));
      tick;
      if (g) n++;
    end
    req = '0;
    tick;
    n = 0;
    rcnt = 0;
    for (int k = 0; k < 9; k++) begin
      g = (k % 3) != 2;
      drive(5'b10000, 0, 32'(4 * n), 0, 0);
      chk("e_rd_gnt", 32'(gnt[4]), 32'(g));
      tick;
      rcnt += int'(rvalid[4]);
      chk("e_rvalid", 32'(rvalid[4]), 32'(g));
      if (g) begin
        chk("e_rdata", rdata[4], 32'hE0 + 32'(n));
        n++;
      end
    end
    req = '0;
    tick;
    chk("e_resp_count", 32'(rcnt), 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
